// File: rtl/memory_request_queue.sv
// Request FIFO that serialises core memory requests onto a single-outstanding
// ap_start/ap_done gateway and returns read data in order over valid/ready.
`timescale 1ns/1ps
module memory_request_queue #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic                    req_wen,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  input  logic [63:0]             base_pointer,
  output logic [63:0]             mem_memory_pointer,
  output logic                    mem_ap_start,
  input  logic                    mem_ap_done,
  input  logic                    mem_ap_idle,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic                    mem_wen,
  input  logic [DATA_WIDTH-1:0]   mem_ap_return,
  output logic [$clog2(DEPTH):0]  occupancy,
  output logic                    protocol_error
);

  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned OCC_W = PW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   addr_q  [DEPTH];
  logic [DATA_WIDTH-1:0]   wdata_q [DEPTH];
  logic [DEPTH-1:0]        wen_q;
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic                    push;
  logic                    pop;

  assign req_ready          = occupancy < OCC_W'(DEPTH);
  assign push               = req_valid && req_ready;
  assign pop                = (state == WAIT) && mem_ap_done;
  assign mem_memory_pointer = base_pointer;

  // The head entry is presented continuously; it cannot change before the pop.
  assign mem_addr  = addr_q[rd_ptr];
  assign mem_wdata = wdata_q[rd_ptr];
  assign mem_wen   = wen_q[rd_ptr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i]  <= '0;
        wdata_q[i] <= '0;
      end
      wen_q  <= '0;
      wr_ptr <= '0;
    end else if (push) begin
      addr_q[wr_ptr]  <= req_addr;
      wdata_q[wr_ptr] <= req_wdata;
      wen_q[wr_ptr]   <= req_wen;
      wr_ptr          <= wr_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      occupancy <= '0;
    end else begin
      case ({push, pop})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      rd_ptr         <= '0;
      mem_ap_start   <= 1'b0;
      resp_valid     <= 1'b0;
      resp_rdata     <= '0;
      protocol_error <= 1'b0;
    end else begin
      if (mem_ap_done && (state != WAIT)) begin
        protocol_error <= 1'b1;
      end
      case (state)
        IDLE: begin
          if ((occupancy != '0) && mem_ap_idle) begin
            state        <= ISSUE;
            mem_ap_start <= 1'b1;
          end
        end
        ISSUE: begin
          state        <= WAIT;
          mem_ap_start <= 1'b0;
        end
        WAIT: begin
          if (mem_ap_done) begin
            rd_ptr <= rd_ptr + 1'b1;
            if (!wen_q[rd_ptr]) begin
              resp_rdata <= mem_ap_return;
              resp_valid <= 1'b1;
              state      <= RESP;
            end else begin
              state <= IDLE;
            end
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_request_queue.sv
// Bench for memory_request_queue: gateway model with fixed latency, request and
// response scoreboard with its own memory image, directed corner sequences.
`timescale 1ns/1ps
module tb_memory_request_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 64;
  localparam int DW    = 16;
  localparam int L     = 4;

  logic            clock = 1'b0;
  logic            reset_n;
  logic            req_valid, req_ready, req_wen;
  logic [AW-1:0]   req_addr;
  logic [DW-1:0]   req_wdata;
  logic            resp_valid, resp_ready;
  logic [DW-1:0]   resp_rdata;
  logic [63:0]     base_pointer, mem_memory_pointer;
  logic            mem_ap_start, mem_ap_done, mem_ap_idle, mem_wen;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata, mem_ap_return;
  logic [2:0]      occupancy;
  logic            protocol_error;

  typedef struct {
    logic          wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  typedef struct {
    logic          wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            exp_occ;
    logic          exp_ready;
    logic [AW-1:0] exp_head;
  } vec_t;

  int checks = 0, errors = 0, cycle = 0;
  req_t        ref_req[$];
  logic [DW-1:0] exp_resp[$];
  logic [DW-1:0] refmem [logic [AW-1:0]];
  logic [DW-1:0] gmem   [logic [AW-1:0]];
  int          ref_occ = 0, start_count = 0, resp_count = 0, last_read_issue = 0, gw_cnt = 0;
  logic        exp_perr = 1'b0, prev_rv = 1'b0, last_acc = 1'b0;
  logic        gw_busy = 1'b0, gw_done = 1'b0, gw_hold = 1'b0, inj_done = 1'b0;
  logic [DW-1:0] gw_ret = '0, last_rdata = '0;
  req_t        gw_cur;

  assign mem_ap_done   = gw_done | inj_done;
  assign mem_ap_idle   = !gw_busy && !gw_hold;
  assign mem_ap_return = gw_ret;

  always #5 clock = ~clock;

  memory_request_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wen(req_wen),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .base_pointer(base_pointer), .mem_memory_pointer(mem_memory_pointer),
    .mem_ap_start(mem_ap_start), .mem_ap_done(mem_ap_done), .mem_ap_idle(mem_ap_idle),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen),
    .mem_ap_return(mem_ap_return), .occupancy(occupancy), .protocol_error(protocol_error)
  );

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return a[15:0] ^ 16'hA5C3;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired or unexpected event (cycle %0d)", name, cycle);
  endtask

  // Gateway: start seen in cycle c -> done during cycle c+L+1, idle again after.
  task automatic gw_step();
    req_t e;
    if (gw_done) begin
      gw_done = 1'b0;
      gw_busy = 1'b0;
    end else if (gw_busy) begin
      gw_cnt--;
      if (gw_cnt == 0) begin
        gw_done = 1'b1;
        if (gw_cur.wen) gmem[gw_cur.addr] = gw_cur.wdata;
        else gw_ret = gmem.exists(gw_cur.addr) ? gmem[gw_cur.addr] : init_val(gw_cur.addr);
      end
    end
    if (mem_ap_start) begin
      start_count++;
      chk("start_while_busy", 64'(gw_busy), 64'(0));
      gw_busy = 1'b1;
      gw_cnt  = L + 1;
      gw_cur  = '{mem_wen, mem_addr, mem_wdata};
      if (!mem_wen) last_read_issue = cycle;
      if (ref_req.size() == 0) fail_now("issue_unexpected");
      else begin
        e = ref_req.pop_front();
        chk("issue_addr", mem_addr, e.addr);
        chk("issue_wen", 64'(mem_wen), 64'(e.wen));
        if (e.wen) chk("issue_wdata", 64'(mem_wdata), 64'(e.wdata));
      end
    end
  endtask

  task automatic model_clear();
    ref_req.delete(); exp_resp.delete(); refmem.delete(); gmem.delete();
    ref_occ = 0; gw_busy = 1'b0; gw_done = 1'b0; gw_ret = '0; gw_hold = 1'b0;
    inj_done = 1'b0; exp_perr = 1'b0; prev_rv = 1'b0;
  endtask

  task automatic tick();
    logic acc, popd;
    if (resp_valid && resp_ready) begin
      resp_count++;
      last_rdata = resp_rdata;
      if (exp_resp.size() == 0) begin
        checks++; errors++;
        $display("FAIL resp_unexpected: got %0h, required no response", resp_rdata);
      end else chk("resp_rdata", 64'(resp_rdata), 64'(exp_resp.pop_front()));
    end
    chk("req_ready", 64'(req_ready), 64'(ref_occ < DEPTH));
    acc = req_valid && (ref_occ < DEPTH);
    if (acc) begin
      ref_req.push_back('{req_wen, req_addr, req_wdata});
      if (req_wen) refmem[req_addr] = req_wdata;
      else exp_resp.push_back(refmem.exists(req_addr) ? refmem[req_addr] : init_val(req_addr));
    end
    popd     = gw_done;
    ref_occ  = ref_occ + int'(acc) - int'(popd);
    last_acc = acc;
    @(posedge clock);
    @(negedge clock);
    cycle++;
    gw_step();
    chk("occupancy", 64'(occupancy), 64'(ref_occ));
    chk("protocol_error", 64'(protocol_error), 64'(exp_perr));
    chk("mem_memory_pointer", mem_memory_pointer, base_pointer);
    if (resp_valid && !prev_rv) chk("resp_latency", 64'(cycle - last_read_issue), 64'(L + 2));
    prev_rv = resp_valid;
  endtask

  task automatic push_req(input logic wen, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid = 1'b1; req_wen = wen; req_addr = a; req_wdata = d;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (last_acc) break;
    end
    if (!last_acc) fail_now("push_timeout");
    req_valid = 1'b0;
  endtask

  task automatic drain();
    logic done_f;
    done_f = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (ref_occ == 0 && exp_resp.size() == 0 && !gw_busy && !resp_valid) begin
        done_f = 1'b1;
        break;
      end
      tick();
    end
    if (!done_f) fail_now("drain_timeout");
  endtask

  task automatic check_reset_values();
    chk("rst_req_ready", 64'(req_ready), 64'(1));
    chk("rst_occupancy", 64'(occupancy), 64'(0));
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_resp_rdata", 64'(resp_rdata), 64'(0));
    chk("rst_ap_start", 64'(mem_ap_start), 64'(0));
    chk("rst_protocol_error", 64'(protocol_error), 64'(0));
    chk("rst_mem_addr", mem_addr, 64'(0));
    chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    chk("rst_mem_wen", 64'(mem_wen), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    int   s0, r0;

    reset_n = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0;
    resp_ready = 1'b1; base_pointer = 64'h1234_5678_9ABC_DEF0;
    #1 reset_n = 1'b0;
    #1 check_reset_values();
    @(negedge clock); @(negedge clock);
    reset_n = 1'b1;

    // Table: gateway held busy so entries accumulate; last offer must be refused.
    vecs[0] = '{1'b1, 64'h10, 16'hBEEF, 1, 1'b1, 64'h10};
    vecs[1] = '{1'b0, 64'h10, 16'h0000, 2, 1'b1, 64'h10};
    vecs[2] = '{1'b0, 64'h20, 16'h0000, 3, 1'b1, 64'h10};
    vecs[3] = '{1'b1, 64'h20, 16'h1234, 4, 1'b0, 64'h10};
    vecs[4] = '{1'b0, 64'h30, 16'h0000, 4, 1'b0, 64'h10};
    gw_hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_wen = vecs[i].wen; req_addr = vecs[i].addr; req_wdata = vecs[i].wdata;
      tick();
      req_valid = 1'b0;
      chk("tbl_occupancy", 64'(occupancy), 64'(vecs[i].exp_occ));
      chk("tbl_req_ready", 64'(req_ready), 64'(vecs[i].exp_ready));
      chk("tbl_head_addr", mem_addr, vecs[i].exp_head);
    end
    chk("tbl_head_wdata", 64'(mem_wdata), 64'hBEEF);
    chk("tbl_head_wen", 64'(mem_wen), 64'(1));
    chk("tbl_no_start", 64'(start_count), 64'(0));
    gw_hold = 1'b0;
    drain();

    // Write then read the same address.
    s0 = start_count; r0 = resp_count;
    push_req(1'b1, 64'h10, 16'hBEEF);
    push_req(1'b0, 64'h10, 16'h0000);
    drain();
    chk("wr_rd_starts", 64'(start_count - s0), 64'(2));
    chk("wr_rd_resps", 64'(resp_count - r0), 64'(1));
    chk("wr_rd_data", 64'(last_rdata), 64'hBEEF);

    // Fill and wrap: six back-to-back reads of addresses 0..5.
    r0 = resp_count;
    for (int i = 0; i < 6; i++) begin
      push_req(1'b0, 64'(i), 16'h0000);
      if (i == 3) begin
        chk("fill_occupancy", 64'(occupancy), 64'(4));
        chk("fill_req_ready", 64'(req_ready), 64'(0));
      end
    end
    drain();
    chk("fill_resps", 64'(resp_count - r0), 64'(6));
    chk("fill_last_data", 64'(last_rdata), 64'(16'h0005 ^ 16'hA5C3));

    // Push coinciding with a WAIT pop at occupancy 2.
    gw_hold = 1'b1;
    push_req(1'b1, 64'h40, 16'h1111);
    push_req(1'b1, 64'h41, 16'h2222);
    chk("simul_pre_occ", 64'(occupancy), 64'(2));
    gw_hold = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (gw_done) break;
      tick();
    end
    chk("simul_done_seen", 64'(gw_done), 64'(1));
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 64'h42; req_wdata = 16'h3333;
    tick();
    req_valid = 1'b0;
    chk("simul_occ", 64'(occupancy), 64'(2));
    chk("simul_head", mem_addr, 64'h41);
    drain();

    // Stray done in IDLE: sticky error, queued entry untouched.
    gw_hold = 1'b1;
    push_req(1'b0, 64'h55, 16'h0000);
    tick();
    inj_done = 1'b1; exp_perr = 1'b1;
    tick();
    inj_done = 1'b0;
    chk("perr_set", 64'(protocol_error), 64'(1));
    chk("perr_head", mem_addr, 64'h55);
    chk("perr_occ", 64'(occupancy), 64'(1));
    for (int i = 0; i < 3; i++) tick();
    gw_hold = 1'b0;
    drain();
    chk("perr_data", 64'(last_rdata), 64'(16'h0055 ^ 16'hA5C3));
    chk("perr_sticky", 64'(protocol_error), 64'(1));

    // Response stall with pushes continuing until full.
    resp_ready = 1'b0;
    push_req(1'b0, 64'h200, 16'h0000);
    for (int i = 0; i < 100; i++) begin
      if (resp_valid) break;
      tick();
    end
    chk("stall_resp_seen", 64'(resp_valid), 64'(1));
    s0 = start_count;
    for (int i = 0; i < 20; i++) begin
      req_valid = 1'b1; req_wen = 1'b0; req_addr = 64'(32'h300 + i); req_wdata = '0;
      tick();
      chk("stall_resp_valid", 64'(resp_valid), 64'(1));
      chk("stall_rdata", 64'(resp_rdata), 64'(16'h0200 ^ 16'hA5C3));
    end
    req_valid = 1'b0;
    chk("stall_no_start", 64'(start_count - s0), 64'(0));
    chk("stall_occ", 64'(occupancy), 64'(4));
    chk("stall_req_ready", 64'(req_ready), 64'(0));

    // Asynchronous reset mid-clock with a response pending and FIFO full.
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1 check_reset_values();
    model_clear();
    resp_ready = 1'b1;
    @(negedge clock); @(negedge clock);
    reset_n = 1'b1;
    chk("post_rst_ready", 64'(req_ready), 64'(1));
    chk("post_rst_occ", 64'(occupancy), 64'(0));

    // Randomised traffic against the scoreboard.
    for (int i = 0; i < 400; i++) begin
      req_valid    = ($urandom % 3) != 0;
      req_wen      = 1'($urandom % 2);
      req_addr     = 64'h100 + 64'($urandom % 8);
      req_wdata    = 16'($urandom);
      resp_ready   = ($urandom % 4) != 0;
      gw_hold      = ($urandom % 10) == 0;
      base_pointer = {32'($urandom), 32'($urandom)};
      tick();
    end
    req_valid = 1'b0; resp_ready = 1'b1; gw_hold = 1'b0;
    drain();
    chk("rand_req_drained", 64'(ref_req.size()), 64'(0));
    chk("rand_resp_drained", 64'(exp_resp.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
